pcc_stream_acc: RTL
===================

# pcc_stream_acc

Streaming, parametrised popcount-compare accumulator. It is the sequential successor of the single-shot popcount-compare (pcc) block. Each beat carries POS_W positive and NEG_W negative bits. The block accumulates the signed difference of exact popcounts over a frame of up to BEATS beats, adds BIAS, and emits one registered decision per frame (sum_pos + BIAS >= sum_neg). It sits between the feature-vector streamer and the classifier voting logic, with valid/ready on both sides.

## Interface
- POS_W, 6, positive-input bits per beat (>=1)
- NEG_W, 9, negative-input bits per beat (>=1)
- BEATS, 4, maximum beats per frame (>=1)
- BIAS, 0, signed integer added once per frame to the positive side
- DW, derived: clog2(BEATS*max(POS_W,NEG_W)+|BIAS|+1)+1, signed accumulator/result width (7 at defaults)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge
- in_pos  in  POS_W  positive bits of beat
- in_neg  in  NEG_W  negative bits of beat
- in_last  in  1  beat closes frame early (ignored unless transferred)
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready at a rising edge
- out_val  out  1  decision: out_diff >= 0
- out_diff  out  DW  signed frame sum: BIAS + Σpopcount(pos) − Σpopcount(neg)
- out_beats  out  clog2(BEATS+1)  number of beats in the reported frame

## Operation
- State: accumulator acc (signed DW), beat counter cnt (0..BEATS-1), output register {out_valid, out_val, out_diff, out_beats}.
- Per beat: d = popcount(in_pos) − popcount(in_neg). The popcount is exact. The sign is extended to DW. Overflow is impossible by construction of DW.
- Non-closing transfer (cnt < BEATS-1 and !in_last): acc <= acc + d; cnt <= cnt+1.
- Closing transfer (cnt == BEATS-1 or in_last):
  - out_diff <= acc + d; out_val <= (acc + d) >= 0; out_beats <= cnt+1; out_valid <= 1.
  - acc <= BIAS; cnt <= 0.
- in_ready = !out_valid || out_ready. This applies to every beat, closing or not, so the block never overwrites an unconsumed result.
- Output consumed (out_valid && out_ready, no simultaneous closing transfer): out_valid <= 0.
- Simultaneous consume and closing transfer in the same cycle: the new result is loaded and out_valid stays 1 (back-to-back frames at full rate).
- While out_valid && !out_ready: out_* hold stable; in_ready = 0; acc and cnt hold.
- Reset:
  - acc = BIAS, cnt = 0.
  - out_valid = 0, out_val = 0, out_diff = 0, out_beats = 0.
  - Reset mid-frame discards all partial beats. Reset with a pending result drops it.
- BEATS == 1: every transfer closes a frame; in_last is a don't-care.

## Timing
- Throughput: one beat per cycle when out_ready is high.
- Latency: a closing transfer at edge k makes out_valid high from edge k (visible in the cycle after k).
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid or data to in_ready.
- out_* are registered outputs. There is no combinational input-to-output path.
- First beat may be accepted in the first cycle after rst deasserts.

## Test plan
- Defaults: 4 beats in_pos=6'h3F, in_neg=0 -> out_diff=24, out_val=1, out_beats=4; out_valid rises at the 4th transfer edge.
- Tie: 4 beats in_pos=6'b000111, in_neg=9'b000000111 -> out_diff=0, out_val=1 (>= boundary).
- Negative win: 4 beats in_pos=0, in_neg=9'h1FF -> out_diff=-36 (7'b1011100), out_val=0.
- Early close: beat1 pos=6'b000001 neg=0; beat2 pos=0 neg=9'h003 with in_last=1.
  - Expect out_diff=-1, out_val=0, out_beats=2.
  - Next 4-beat frame of pos=6'h01, neg=0 gives out_diff=4 (acc restarted).
- Backpressure: hold out_ready=0 for 3 cycles after a result.
  - Expect in_ready=0 and out_* stable throughout.
  - Then pulse out_ready together with a closing beat: the new result loads with no out_valid bubble.
- Reset mid-frame: 2 beats pos=6'h3F, then rst for 1 cycle, then 4 beats pos=0 neg=9'h001 -> out_diff=-4; no result is emitted for the aborted frame. Repeat with BIAS=2 -> out_diff=-2, out_val=0.

Source files
------------

// File: rtl/pcc_stream_acc.sv
`default_nettype none
// ============================================================================
//  Module      : pcc_stream_acc
//  Description : Streaming popcount-compare accumulator. Each accepted beat
//                contributes popcount(in_pos) - popcount(in_neg) to a signed
//                frame sum seeded with BIAS. A frame closes after BEATS beats
//                or on a transferred in_last. One registered decision
//                (sum >= 0) is emitted per frame over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    POS_W     positive-input bits per beat (>= 1)
//    NEG_W     negative-input bits per beat (>= 1)
//    BEATS     maximum beats per frame (>= 1)
//    BIAS      signed constant added once per frame to the positive side
//    DW        signed accumulator / result width (derived by default)
//  Ports
//    clk, rst              clock, synchronous active-high reset
//    in_valid/in_ready     beat handshake
//    in_pos, in_neg        beat payload
//    in_last               beat closes the frame early
//    out_valid/out_ready   result handshake
//    out_val               decision: out_diff >= 0
//    out_diff              signed frame sum
//    out_beats             number of beats in the reported frame
// ============================================================================
module pcc_stream_acc #(
    parameter int POS_W = 6,
    parameter int NEG_W = 9,
    parameter int BEATS = 4,
    parameter int BIAS  = 0,
    parameter int DW    = $clog2(BEATS * ((POS_W > NEG_W) ? POS_W : NEG_W)
                                 + ((BIAS < 0) ? -BIAS : BIAS) + 1) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [POS_W-1:0]              in_pos,
    input  logic [NEG_W-1:0]              in_neg,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_val,
    output logic signed [DW-1:0]          out_diff,
    output logic [$clog2(BEATS+1)-1:0]    out_beats
);

    // Beat counter needs at least one bit even when BEATS == 1.
    localparam int c_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_OB_W  = $clog2(BEATS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BEATS - 1);
    localparam logic signed [DW-1:0] c_BIAS   = DW'(BIAS);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic signed [DW-1:0]   r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_out_valid;
    logic                   r_out_val;
    logic signed [DW-1:0]   r_out_diff;
    logic [c_OB_W-1:0]      r_out_beats;

    // ------------------------------------------------------------------------
    // Per-beat popcount difference
    // ------------------------------------------------------------------------
    logic [DW-1:0]          w_pc_pos;
    logic [DW-1:0]          w_pc_neg;
    logic signed [DW-1:0]   w_d;
    logic signed [DW-1:0]   w_sum;

    always_comb begin
        w_pc_pos = '0;
        for (int i = 0; i < POS_W; i++) begin
            w_pc_pos = w_pc_pos + DW'(in_pos[i]);
        end
    end

    always_comb begin
        w_pc_neg = '0;
        for (int i = 0; i < NEG_W; i++) begin
            w_pc_neg = w_pc_neg + DW'(in_neg[i]);
        end
    end

    // Both popcounts are non-negative and fit well inside DW, so the
    // two's-complement difference is exact.
    assign w_d   = $signed(w_pc_pos) - $signed(w_pc_neg);
    assign w_sum = r_acc + w_d;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_xfer;
    logic w_close;
    logic w_consume;

    // Ready depends only on the output register and out_ready: an unconsumed
    // result stalls every beat, so it can never be overwritten.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_xfer    = in_valid && in_ready;
    assign w_close   = w_xfer && ((r_cnt == c_CNT_LAST) || in_last);
    assign w_consume = r_out_valid && out_ready;

    // ------------------------------------------------------------------------
    // Accumulator and beat counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= c_BIAS;
            r_cnt <= '0;
        end else if (w_close) begin
            r_acc <= c_BIAS;
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // A closing transfer has priority over a consume so that a result taken
    // in the same cycle a new frame closes is replaced without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_val   <= 1'b0;
            r_out_diff  <= '0;
            r_out_beats <= '0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_val   <= !w_sum[DW-1];
            r_out_diff  <= w_sum;
            r_out_beats <= c_OB_W'(r_cnt) + c_OB_W'(1);
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_val   = r_out_val;
    assign out_diff  = r_out_diff;
    assign out_beats = r_out_beats;

endmodule
`default_nettype wire
